// File: rtl/mult_exec_queued.sv
// Pipelined RV32M multiply unit feeding an in-order result FIFO toward the CDB.
// Issue is credit-gated so every result leaving the pipeline is guaranteed a free FIFO slot.
module mult_exec_queued #(
   parameter int XLEN        = 32,
   parameter int NUM_STAGES  = 3,
   parameter int QUEUE_DEPTH = 4,
   parameter int PREG_W      = 6,
   parameter int ROB_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        issue_funct3,
   input  logic [XLEN-1:0]   issue_ps1,
   input  logic [XLEN-1:0]   issue_ps2,
   input  logic [PREG_W-1:0] issue_pd,
   input  logic [4:0]        issue_rd,
   input  logic [ROB_W-1:0]  issue_rob_idx,
   input  logic [31:0]       issue_pc,
   output logic              cdb_valid,
   input  logic              cdb_dequeue,
   output logic [XLEN-1:0]   cdb_value,
   output logic [PREG_W-1:0] cdb_pd,
   output logic [4:0]        cdb_rd,
   output logic [ROB_W-1:0]  cdb_rob_idx,
   output logic [31:0]       cdb_pc,
   output logic [31:0]       cdb_pc_next
);

   localparam int PTR_W     = $clog2(QUEUE_DEPTH);
   localparam int OCC_W     = PTR_W + 1;
   localparam int CNT_W     = $clog2(NUM_STAGES + QUEUE_DEPTH + 1);
   localparam int PIPE_REGS = NUM_STAGES - 1;
   localparam int PROD_W    = 2 * XLEN + 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   typedef struct packed {
      logic [XLEN-1:0]   value;
      logic [PREG_W-1:0] pd;
      logic [4:0]        rd;
      logic [ROB_W-1:0]  rob_idx;
      logic [31:0]       pc;
   } entry_t;

   mul_op_e                  op;
   logic signed [XLEN:0]     opnd_a;
   logic signed [XLEN:0]     opnd_b;
   logic signed [PROD_W-1:0] wide_a;
   logic signed [PROD_W-1:0] wide_b;
   logic signed [PROD_W-1:0] product;
   logic [XLEN-1:0]          result;
   entry_t                   in_entry;
   logic                     accept;

   logic                     wr_valid;
   entry_t                   wr_entry;
   logic [CNT_W-1:0]         inflight;

   entry_t                   mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [OCC_W-1:0]         occ;
   logic                     deq;
   entry_t                   head;

   logic                     unused_bits;

   // A single (XLEN+1)-bit signed multiply covers all four variants once the extension bit is chosen.
   always_comb begin
      op      = mul_op_e'(issue_funct3[1:0]);
      opnd_a  = {(op != OP_MULHU) & issue_ps1[XLEN-1], issue_ps1};
      opnd_b  = {((op == OP_MUL) || (op == OP_MULH)) & issue_ps2[XLEN-1], issue_ps2};
      wide_a  = PROD_W'(opnd_a);
      wide_b  = PROD_W'(opnd_b);
      product = wide_a * wide_b;
      result  = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
   end

   assign unused_bits = ^{issue_funct3[2], product[PROD_W-1:2*XLEN]};

   always_comb begin
      in_entry         = '0;
      in_entry.value   = result;
      in_entry.pd      = issue_pd;
      in_entry.rd      = issue_rd;
      in_entry.rob_idx = issue_rob_idx;
      in_entry.pc      = issue_pc;
   end

   assign accept = issue_valid && issue_ready && !flush;

   // The FIFO write is the last of the NUM_STAGES registers, so only NUM_STAGES-1 live here.
   generate
      if (PIPE_REGS > 0) begin : g_pipe
         logic   pipe_valid [PIPE_REGS];
         entry_t pipe_data  [PIPE_REGS];

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               for (int i = 0; i < PIPE_REGS; i++) begin
                  pipe_valid[i] <= 1'b0;
               end
            end else begin
               pipe_valid[0] <= accept;
               for (int i = 1; i < PIPE_REGS; i++) begin
                  pipe_valid[i] <= pipe_valid[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            pipe_data[0] <= in_entry;
            for (int i = 1; i < PIPE_REGS; i++) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end

         always_comb begin
            inflight = '0;
            for (int i = 0; i < PIPE_REGS; i++) begin
               inflight = inflight + CNT_W'(pipe_valid[i]);
            end
         end

         assign wr_valid = pipe_valid[PIPE_REGS-1];
         assign wr_entry = pipe_data[PIPE_REGS-1];
      end else begin : g_direct
         assign inflight = '0;
         assign wr_valid = accept;
         assign wr_entry = in_entry;
      end
   endgenerate

   assign deq = cdb_dequeue && cdb_valid;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_valid) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_valid, deq})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_valid) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   assign head      = mem[rd_ptr];
   assign cdb_valid = (occ != '0);

   // Data outputs are forced to zero whenever the queue is empty.
   always_comb begin
      cdb_value   = '0;
      cdb_pd      = '0;
      cdb_rd      = '0;
      cdb_rob_idx = '0;
      cdb_pc      = '0;
      cdb_pc_next = '0;
      if (cdb_valid) begin
         cdb_value   = head.value;
         cdb_pd      = head.pd;
         cdb_rd      = head.rd;
         cdb_rob_idx = head.rob_idx;
         cdb_pc      = head.pc;
         cdb_pc_next = head.pc + 32'd4;
      end
   end

   // Only registered state feeds the credit check, keeping cdb_dequeue off this path.
   assign issue_ready = (inflight + CNT_W'(occ)) < CNT_W'(QUEUE_DEPTH);

endmodule

// File: tb/tb_mult_exec_queued.sv
// Scoreboard bench for mult_exec_queued: the driver pushes expected results on accept,
// a negedge monitor checks every cycle's outputs against the head of that queue.
module tb_mult_exec_queued;

   localparam int XLEN        = 32;
   localparam int NUM_STAGES  = 3;
   localparam int QUEUE_DEPTH = 4;
   localparam int PREG_W      = 6;
   localparam int ROB_W       = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              issue_valid;
   logic              issue_ready;
   logic [2:0]        issue_funct3;
   logic [XLEN-1:0]   issue_ps1;
   logic [XLEN-1:0]   issue_ps2;
   logic [PREG_W-1:0] issue_pd;
   logic [4:0]        issue_rd;
   logic [ROB_W-1:0]  issue_rob_idx;
   logic [31:0]       issue_pc;
   logic              cdb_valid;
   logic              cdb_dequeue;
   logic [XLEN-1:0]   cdb_value;
   logic [PREG_W-1:0] cdb_pd;
   logic [4:0]        cdb_rd;
   logic [ROB_W-1:0]  cdb_rob_idx;
   logic [31:0]       cdb_pc;
   logic [31:0]       cdb_pc_next;

   typedef struct {
      logic [31:0]       value;
      logic [PREG_W-1:0] pd;
      logic [4:0]        rd;
      logic [ROB_W-1:0]  rob;
      logic [31:0]       pc;
      int                issue_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic mon_exp_valid;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;

   mult_exec_queued #(
      .XLEN(XLEN), .NUM_STAGES(NUM_STAGES), .QUEUE_DEPTH(QUEUE_DEPTH),
      .PREG_W(PREG_W), .ROB_W(ROB_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct3(issue_funct3),
      .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd), .issue_rd(issue_rd),
      .issue_rob_idx(issue_rob_idx), .issue_pc(issue_pc),
      .cdb_valid(cdb_valid), .cdb_dequeue(cdb_dequeue), .cdb_value(cdb_value),
      .cdb_pd(cdb_pd), .cdb_rd(cdb_rd), .cdb_rob_idx(cdb_rob_idx),
      .cdb_pc(cdb_pc), .cdb_pc_next(cdb_pc_next)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f3[1:0])
         2'b01:   p = sa * sb;
         2'b10:   p = sa * longint'(ub);
         default: p = ua * ub;
      endcase
      return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Called just after a posedge; returns just after the following posedge.
   task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_value,
                                input logic deq, input logic fl, input logic rs, output logic acc);
      logic r1;
      logic r2;
      exp_t e;
      issue_valid   = v;
      issue_funct3  = f3;
      issue_ps1     = a;
      issue_ps2     = b;
      issue_pd      = PREG_W'($urandom);
      issue_rd      = 5'($urandom);
      issue_rob_idx = ROB_W'($urandom);
      issue_pc      = $urandom;
      cdb_dequeue   = deq;
      flush         = fl;
      rst           = rs;
      #1 r1 = issue_ready;
      cdb_dequeue = ~deq;
      #1 r2 = issue_ready;
      cdb_dequeue = deq;
      if (mon_en) checkOutput("ready_vs_dequeue", 64'(r2), 64'(r1));
      @(negedge clk);
      #2;
      acc = v && issue_ready && !fl && !rs;
      if (acc) begin
         e.value     = exp_value;
         e.pd        = issue_pd;
         e.rd        = issue_rd;
         e.rob       = issue_rob_idx;
         e.pc        = issue_pc;
         e.issue_cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic deq);
      logic acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, deq, 1'b0, 1'b0, acc);
   endtask

   // Monitor: model head is present once NUM_STAGES cycles have passed since its issue.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_exp_valid = (exp_q.size() > 0) && (exp_q[0].issue_cyc + NUM_STAGES <= cyc);
         checkOutput("issue_ready", 64'(issue_ready), 64'(exp_q.size() < QUEUE_DEPTH));
         checkOutput("cdb_valid", 64'(cdb_valid), 64'(mon_exp_valid));
         checkOutput("occ_bound", 64'(dut.occ <= 3'(QUEUE_DEPTH)), 64'd1);
         checkOutput("no_write_when_full", 64'(dut.wr_valid && (dut.occ == 3'(QUEUE_DEPTH))), 64'd0);
         if (mon_exp_valid) begin
            mon_e = exp_q[0];
            checkOutput("cdb_value", 64'(cdb_value), 64'(mon_e.value));
            checkOutput("cdb_tags", 64'({cdb_pd, cdb_rd, cdb_rob_idx}), 64'({mon_e.pd, mon_e.rd, mon_e.rob}));
            checkOutput("cdb_pc", 64'(cdb_pc), 64'(mon_e.pc));
            checkOutput("cdb_pc_next", 64'(cdb_pc_next), 64'(mon_e.pc + 32'd4));
            if (cdb_dequeue) void'(exp_q.pop_front());
         end else begin
            checkOutput("cdb_idle_data",
                        64'(cdb_value | cdb_pc | cdb_pc_next) | 64'({cdb_pd, cdb_rd, cdb_rob_idx}), 64'd0);
         end
         if (rst || flush) exp_q.delete();
      end
   end

   initial begin
      #1_000_000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] t1_exp [4];
      logic [2:0]  t2_f3  [6];
      logic [31:0] t2_a   [6];
      logic [31:0] t2_b   [6];
      logic [31:0] t2_exp [6];
      logic        acc;
      int          n_acc;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;

      t1_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      t2_f3  = '{3'd1, 3'd3, 3'd2, 3'd0, 3'b100, 3'b101};
      t2_a   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd3, 32'hFFFF_FFFD};
      t2_b   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
      t2_exp = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 32'd15, 32'hFFFF_FFFF};

      rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_funct3 = '0;
      issue_ps1 = '0; issue_ps2 = '0; issue_pd = '0; issue_rd = '0;
      issue_rob_idx = '0; issue_pc = '0; cdb_dequeue = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      $display("[TB] all four funct3 variants on -1 * 2");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 3'(i), 32'hFFFF_FFFF, 32'h2, t1_exp[i], 1'b1, 1'b0, 1'b0, acc);
      idle(6, 1'b1);

      $display("[TB] 0x80000000 squared and funct3 bit 2 ignored");
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, t2_f3[i], t2_a[i], t2_b[i], t2_exp[i], 1'b1, 1'b0, 1'b0, acc);
      idle(6, 1'b1);

      $display("[TB] credit exhaustion with dequeue held low");
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'd0, 32'(i + 1), 32'd7, 32'(7 * (i + 1)), 1'b0, 1'b0, 1'b0, acc);
         if (acc) n_acc++;
      end
      checkOutput("fill_accepts", 64'(n_acc), 64'd4);
      idle(6, 1'b1);

      $display("[TB] flush with three queued results and an issue pending");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 3'd0, 32'(i), 32'd3, 32'(3 * i), 1'b0, 1'b0, 1'b0, acc);
      idle(3, 1'b0);
      checkOutput("pre_flush_occ", 64'(dut.occ), 64'd3);
      applyStimulus(1'b1, 3'd0, 32'd9, 32'd9, 32'd81, 1'b1, 1'b1, 1'b0, acc);
      checkOutput("flush_cdb_valid", 64'(cdb_valid), 64'd0);
      checkOutput("flush_issue_ready", 64'(issue_ready), 64'd1);
      idle(6, 1'b1);

      $display("[TB] reset with work in pipeline and queue");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 3'd1, 32'(i + 2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 3'd0, 32'd4, 32'd4, 32'd16, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      checkOutput("rst_issue_ready", 64'(issue_ready), 64'd1);
      checkOutput("rst_cdb_data", 64'(cdb_value | cdb_pc | cdb_pc_next), 64'd0);
      checkOutput("rst_pointers", 64'({dut.wr_ptr, dut.rd_ptr}), 64'd0);
      for (int i = 0; i < 20; i++) begin
         f3 = 3'($urandom); a = $urandom; b = $urandom;
         applyStimulus(1'b1, f3, a, b, ref_mul(f3, a, b), 1'b1, 1'b0, 1'b0, acc);
      end
      idle(6, 1'b1);

      $display("[TB] random issue/dequeue with occasional flush");
      for (int i = 0; i < 10000; i++) begin
         f3 = 3'($urandom); a = $urandom; b = $urandom;
         applyStimulus($urandom_range(0, 9) < 7, f3, a, b, ref_mul(f3, a, b),
                       $urandom_range(0, 9) < 6, $urandom_range(0, 999) == 0, 1'b0, acc);
      end
      idle(20, 1'b1);
      checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_exec_queued.md
# mult_exec_queued

Parametrised, non-stalling pipelined RV32M multiplier execution unit with an internal result queue, a credit-based issue handshake and a flush path. It sits between the multiply reservation station and the CDB arbiter. Decoupling the pipeline from CDB backpressure with a FIFO lets the arithmetic stages advance every cycle. Flush discards all speculative work.

## Interface
Parameters:
- XLEN, 32: operand and result width.
- NUM_STAGES, 3: pipeline register stages from issue to queue, ≥1.
- QUEUE_DEPTH, 4: result FIFO entries, power of two, ≥2.
- PREG_W, 6: physical register index width.
- ROB_W, 4: ROB index width.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: kill all in-flight and queued operations.
- issue_valid, in, 1: RS presents an operation.
- issue_ready, out, 1: unit accepts an operation this cycle.
- issue_funct3, in, 3: [1:0] selects 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored.
- issue_ps1, issue_ps2, in, XLEN: source operand values.
- issue_pd, in, PREG_W; issue_rd, in, 5; issue_rob_idx, in, ROB_W; issue_pc, in, 32: tags carried with the op.
- cdb_valid, out, 1: queue head holds a result.
- cdb_dequeue, in, 1: arbiter consumes the head this cycle.
- cdb_value, out, XLEN; cdb_pd, out, PREG_W; cdb_rd, out, 5; cdb_rob_idx, out, ROB_W; cdb_pc, out, 32; cdb_pc_next, out, 32: head result and tags. cdb_pc_next = cdb_pc + 4.

## Operation
- Accept when issue_valid && issue_ready and not flush.
- Operand extension to XLEN+1 bits:
  - MUL and MULH: both operands sign-extended.
  - MULHSU: ps1 sign-extended, ps2 zero-extended.
  - MULHU: both operands zero-extended.
- Form a signed (2·XLEN+2)-bit product.
- Result selection: MUL takes product[XLEN-1:0]; all other ops take product[2·XLEN-1:XLEN].
- The product is carried with its tags through NUM_STAGES valid-tagged registers. Synthesis may retime it. Stages never stall.
- The final stage writes the result into the FIFO. The FIFO head drives the cdb_* outputs.
- Credit counting:
  - inflight = number of valid pipeline stages.
  - occ = FIFO occupancy.
  - issue_ready = (inflight + occ) < QUEUE_DEPTH, computed from registered state only. There is no combinational path from cdb_dequeue to issue_ready.
- The FIFO therefore never overflows. A pipeline write into a full FIFO is a bug; the bench asserts against it.
- cdb_dequeue while cdb_valid = 0 is ignored.
- A FIFO write and a dequeue in the same cycle are both performed, and occupancy is unchanged.
- When cdb_valid = 0, all cdb_* data outputs read 0.
- Flush: at the next edge, clear all stage valids and FIFO pointers/occupancy. An issue presented in the flush cycle is dropped. cdb_dequeue in the flush cycle has no further effect.
- Reset has priority over flush.
- Reset values: issue_ready = 1, cdb_valid = 0, all cdb_* data = 0, pointers = 0, all stage valids = 0.

## Timing
- Issue accepted in cycle T → cdb_valid = 1 in cycle T+NUM_STAGES if the FIFO was empty. Otherwise the result appears after the entries ahead of it are dequeued.
- Results leave in issue order.
- Throughput is one op per cycle while credits remain. Sustained full rate requires QUEUE_DEPTH > NUM_STAGES and cdb_dequeue every cycle.
- A dequeue in cycle T frees a credit visible as issue_ready in cycle T+1.
- Flush or reset asserted in cycle T → cdb_valid = 0 and issue_ready = 1 in cycle T+1.
- Pointers wrap modulo QUEUE_DEPTH.

## Test plan
- ps1 = 0xFFFFFFFF, ps2 = 0x00000002, issued for each funct3 on consecutive cycles → MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x00000001. Each result appears NUM_STAGES cycles after its issue, in order, with matching tags.
- ps1 = ps2 = 0x80000000 → MULH 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000, MUL 0x00000000.
- Defaults, cdb_dequeue held low, issue_valid every cycle → exactly 4 ops accepted. issue_ready stays low from the 5th cycle on, and no result is lost. Then dequeue every cycle → 4 results, in order. issue_ready rises the cycle after the first dequeue.
- Fill FIFO to 3 entries, then assert flush with issue_valid high → next cycle cdb_valid = 0 and issue_ready = 1. The dropped op never appears.
- Pulse rst with ops in pipeline and FIFO → all outputs at reset values next cycle. 20 random back-to-back ops afterwards match a reference model.
- Random issue and random dequeue for 10k cycles with FIFO wrap-around → results match the reference model, occupancy never exceeds QUEUE_DEPTH, and issue_ready never depends combinationally on cdb_dequeue.
